// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder/accumulator.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_ACC = 1'b1;

endpackage : serial_add_pkg

// File: rtl/full_adder_cell.sv
// Single combinational full-adder cell, reused every cycle by the serial datapath.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule : full_adder_cell

// File: rtl/serial_add_acc.sv
// Bit-serial W-bit adder/accumulator with start/busy/done handshake.
// Optional subtract support is enabled by defining SERIAL_ADD_SUB_EN.
module serial_add_acc
  import serial_add_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic         start,
  input  logic         mode,
  input  logic         clr,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
`ifdef SERIAL_ADD_SUB_EN
  input  logic         sub,
`endif
  output logic         busy,
  output logic         done,
  output logic [W:0]   sum,
  output logic [W-1:0] acc
);

  localparam int CW = $clog2(W);

  state_t        state;
  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic [W-1:0]  res;
  logic          carry;
  logic [CW-1:0] cnt;
  logic          mode_q;
  logic          sub_q;
  logic          sub_start;

  logic          fa_b;
  logic          fa_s;
  logic          fa_cout;
  logic [W-1:0]  res_next;

`ifdef SERIAL_ADD_SUB_EN
  assign sub_start = sub;
`else
  assign sub_start = 1'b0;
`endif

  // Subtraction is A + ~B + 1: invert B into the cell, seed the carry with 1.
  assign fa_b     = b_sh[0] ^ sub_q;
  assign res_next = {fa_s, res[W-1:1]};

  full_adder_cell u_fa (
    .a    (a_sh[0]),
    .b    (fa_b),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // NOTE: all state below is sequential, so it uses non-blocking assignments only;
  // blocking here would let later statements see half-updated values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      acc    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      res    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      mode_q <= MODE_ADD;
      sub_q  <= 1'b0;
    end else if (ena) begin
      if (clr) acc <= '0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= a_in;
            b_sh   <= (mode == MODE_ACC) ? (clr ? '0 : acc) : b_in;
            carry  <= sub_start;
            cnt    <= '0;
            mode_q <= mode;
            sub_q  <= sub_start;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= fa_cout;
          res   <= res_next;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(W - 1)) begin
            state <= DONE;
            done  <= 1'b1;
            sum   <= {fa_cout, res_next};
            // A simultaneous clear takes priority over the accumulate write-back.
            if (mode_q == MODE_ACC && !clr) acc <= res_next;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule : serial_add_acc

// File: tb/tb_serial_add_acc.sv
// Scoreboard bench for serial_add_acc (W=8); covers SERIAL_ADD_SUB_EN when defined.
module tb_serial_add_acc;
  import serial_add_pkg::*;

  localparam int W = 8;

  typedef struct {
    logic [W:0]   sum;
    logic [W-1:0] acc;
    int           done_cycle;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ena = 1'b1;
  logic         start = 1'b0;
  logic         mode = MODE_ADD;
  logic         clr = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub = 1'b0;
`endif
  logic         busy;
  logic         done;
  logic [W:0]   sum;
  logic [W-1:0] acc;

  exp_t q[$];
  int   cycle = 0;
  int   n_pass = 0;
  int   n_total = 0;
  int   n_done = 0;
  int   n_ops = 0;

  serial_add_acc #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .start (start),
    .mode  (mode),
    .clr   (clr),
    .a_in  (a_in),
    .b_in  (b_in),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .acc   (acc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: on each rising edge of done, pop and compare the next expected result.
  initial begin : monitor
    logic done_prev;
    exp_t e;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !done_prev) begin
        n_done++;
        check("done_expected", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          e = q.pop_front();
          check("sum", 32'(sum), 32'(e.sum));
          check("acc", 32'(acc), 32'(e.acc));
          check("latency", 32'(cycle), 32'(e.done_cycle));
        end
      end
      done_prev = done;
    end
  end

  // Issue one accepted operation and queue its expected response.
  task automatic issue(input logic m, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input logic s, input logic [W:0] exp_sum,
                       input logic [W-1:0] exp_acc, input int lat);
    exp_t e;
    @(negedge clk);
    mode  = m;
    a_in  = a;
    b_in  = b;
    clr   = c;
`ifdef SERIAL_ADD_SUB_EN
    sub   = s;
`endif
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    clr   = 1'b0;
    e.sum = exp_sum;
    e.acc = exp_acc;
    e.done_cycle = cycle + lat;
    q.push_back(e);
    n_ops++;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin : driver
    int busy_cnt;
    // Reset state
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_acc", 32'(acc), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD 0x5A + 0x3C, with busy-width measurement
    issue(MODE_ADD, 8'h5A, 8'h3C, 1'b0, 1'b0, 9'h096, 8'h00, 8);
    busy_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      else break;
    end
    check("busy_width", 32'(busy_cnt), 32'd9);
    wait_idle();

    // Carry out
    issue(MODE_ADD, 8'hFF, 8'h01, 1'b0, 1'b0, 9'h100, 8'h00, 8);
    wait_idle();

    // Standalone clear, then two accumulations of 0x80
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_acc", 32'(acc), 32'd0);
    issue(MODE_ACC, 8'h80, 8'h55, 1'b0, 1'b0, 9'h080, 8'h80, 8);
    wait_idle();
    issue(MODE_ACC, 8'h80, 8'h55, 1'b0, 1'b0, 9'h100, 8'h00, 8);
    wait_idle();

    // start pulsed again mid-RUN is ignored
    issue(MODE_ADD, 8'h12, 8'h34, 1'b0, 1'b0, 9'h046, 8'h00, 8);
    repeat (3) @(negedge clk);
    a_in  = 8'hFF;
    b_in  = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (12) @(negedge clk);

    // ena low for 3 cycles mid-RUN stretches latency to 11
    issue(MODE_ADD, 8'h11, 8'h22, 1'b0, 1'b0, 9'h033, 8'h00, 11);
    repeat (3) @(negedge clk);
    ena = 1'b0;
    repeat (3) @(negedge clk);
    ena = 1'b1;
    wait_idle();

    // ACC 0x10 from 0, then clr with accepting start loads B=0
    issue(MODE_ACC, 8'h10, 8'h00, 1'b0, 1'b0, 9'h010, 8'h10, 8);
    wait_idle();
    issue(MODE_ACC, 8'h05, 8'hAA, 1'b1, 1'b0, 9'h005, 8'h05, 8);
    wait_idle();

    // clr on the final RUN edge: acc cleared, sum keeps full result 0x03 + 0x05
    issue(MODE_ACC, 8'h03, 8'h00, 1'b0, 1'b0, 9'h008, 8'h00, 8);
    repeat (8) @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    wait_idle();

`ifdef SERIAL_ADD_SUB_EN
    issue(MODE_ADD, 8'h05, 8'h07, 1'b0, 1'b1, 9'h0FE, 8'h00, 8);
    wait_idle();
    issue(MODE_ADD, 8'h07, 8'h05, 1'b0, 1'b1, 9'h102, 8'h00, 8);
    wait_idle();
    sub = 1'b0;
`endif

    // Asynchronous reset mid-RUN aborts with no done pulse
    @(negedge clk);
    mode  = MODE_ADD;
    a_in  = 8'h33;
    b_in  = 8'h44;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_acc", 32'(acc), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("post_abort_busy", 32'(busy), 32'd0);

    check("queue_drained", 32'(q.size()), 32'd0);
    check("done_count", 32'(n_done), 32'(n_ops));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule : tb_serial_add_acc
